// File: rtl/viol_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viol_pkg
// Brief    : Shared record kinds, escalation state encoding, record width.
// Revision : 1.0
// ============================================================================
package viol_pkg;

    localparam logic [1:0] KIND_R  = 2'b01;
    localparam logic [1:0] KIND_J  = 2'b10;
    localparam logic [1:0] KIND_RJ = 2'b11;

    localparam int REC_W = 34;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALERT    = 2'd1,
        ST_HALT_REQ = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

endpackage : viol_pkg
`default_nettype wire

// File: rtl/violation_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : violation_logger_if
// Brief    : Record drain handshake between the logger and the host.
// Revision : 1.0
// ============================================================================
interface violation_logger_if;

    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_pc;
    logic [1:0]  rec_kind;

    modport master (
        output rec_valid,
        output rec_pc,
        output rec_kind,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_pc,
        input  rec_kind,
        output rec_ready
    );

endinterface : violation_logger_if
`default_nettype wire

// File: rtl/viol_fifo.sv
`default_nettype none
// ============================================================================
// Module   : viol_fifo
// Brief    : Synchronous FIFO with a registered head word and valid flag.
// Revision : 1.0
// ============================================================================
module viol_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] din_i,
    input  wire logic             pop_i,
    output logic                  full_o,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      dout_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;

    logic w_full, w_empty, w_pop, w_push_ok;

    assign w_full    = (count_q == (AW+1)'(DEPTH));
    assign w_empty   = (count_q == '0);
    assign w_pop     = pop_i & ~w_empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_push_ok = push_i & (~w_full | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(w_push_ok);
        rd_ptr_d = rd_ptr_q + AW'(w_pop);
        count_d  = count_q + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
        // Forward the incoming word when it lands on the new head slot.
        if (w_push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = din_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
        end
    end

    assign full_o  = w_full;
    assign valid_o = valid_q;
    assign dout_o  = head_q;

endmodule : viol_fifo
`default_nettype wire

// File: rtl/violation_logger.sv
`default_nettype none
// ============================================================================
// Module   : violation_logger
// Brief    : Aligns monitor flags to their instruction, logs violation records,
//            keeps saturating per-kind counters and escalates irq / halt_req.
// Revision : 1.0
// ============================================================================
module violation_logger
    import viol_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int THRESH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [31:0]      pc,
    input  wire logic             inst_valid,
    input  wire logic             r,
    input  wire logic             j,
    violation_logger_if.master    rec,
    output logic [CNT_W-1:0]      r_count,
    output logic [CNT_W-1:0]      j_count,
    output logic                  ovf,
    output logic                  irq,
    output logic                  halt_req,
    input  wire logic             halt_ack,
    input  wire logic             clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      pc_q;
    logic             v_q;
    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic [CNT_W-1:0] j_cnt_q, j_cnt_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;

    logic             w_viol;
    logic [1:0]       w_kind;
    logic [CNT_W:0]   w_total;
    logic             w_thresh_hit;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic [REC_W-1:0] w_head;

    // Flags arrive one cycle after their PC; the registered slot masks stale flags.
    assign w_viol = v_q & (r | j);
    assign w_kind = {j, r};
    assign w_pop  = w_valid & rec.rec_ready;

    always_comb begin
        r_cnt_d = r_cnt_q;
        j_cnt_d = j_cnt_q;
        ovf_d   = ovf_q;
        if (w_viol && r && (r_cnt_q != CNT_MAX)) begin
            r_cnt_d = r_cnt_q + 1'b1;
        end
        if (w_viol && j && (j_cnt_q != CNT_MAX)) begin
            j_cnt_d = j_cnt_q + 1'b1;
        end
        if (w_viol && w_full && !w_pop) begin
            ovf_d = 1'b1;
        end
        if (clr) begin
            r_cnt_d = '0;
            j_cnt_d = '0;
            ovf_d   = 1'b0;
        end
    end

    assign w_total      = {1'b0, r_cnt_d} + {1'b0, j_cnt_d};
    assign w_thresh_hit = (THRESH != 0) && (w_total >= (CNT_W+1)'(THRESH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_viol) begin
                    state_d = w_thresh_hit ? ST_HALT_REQ : ST_ALERT;
                end
            end
            ST_ALERT: begin
                if (w_thresh_hit) begin
                    state_d = ST_HALT_REQ;
                end
            end
            ST_HALT_REQ: begin
                if (halt_ack) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clr) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            v_q     <= 1'b0;
            r_cnt_q <= '0;
            j_cnt_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            pc_q    <= pc;
            v_q     <= inst_valid;
            r_cnt_q <= r_cnt_d;
            j_cnt_q <= j_cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    viol_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_viol),
        .din_i   ({pc_q, w_kind}),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .valid_o (w_valid),
        .dout_o  (w_head)
    );

    assign rec.rec_valid = w_valid;
    assign rec.rec_pc    = w_head[REC_W-1:2];
    assign rec.rec_kind  = w_head[1:0];

    assign r_count  = r_cnt_q;
    assign j_count  = j_cnt_q;
    assign ovf      = ovf_q;
    assign irq      = (state_q != ST_IDLE);
    assign halt_req = (state_q == ST_HALT_REQ);

endmodule : violation_logger
`default_nettype wire
